// File: rtl/max7219_pkg.sv
// max7219_pkg: MAX7219 register map, driver FSM states and SPI word helpers.
package max7219_pkg;
   localparam logic [3:0] REG_NOOP       = 4'h0;
   localparam logic [3:0] REG_DIGIT0     = 4'h1;
   localparam logic [3:0] REG_DECODE     = 4'h9;
   localparam logic [3:0] REG_INTENSITY  = 4'hA;
   localparam logic [3:0] REG_SCAN_LIMIT = 4'hB;
   localparam logic [3:0] REG_SHUTDOWN   = 4'hC;
   localparam logic [3:0] REG_TEST       = 4'hF;

   typedef enum logic [2:0] {S_INIT, S_IDLE, S_LOAD, S_SHIFT, S_GAP} state_t;

   function automatic logic [15:0] build_word(input logic [3:0] addr, input logic [7:0] data);
      return {4'h0, addr, data};
   endfunction

   // lowest set position, 0 when empty
   function automatic logic [2:0] first_set(input logic [7:0] m);
      logic [2:0] r;
      r = 3'd0;
      for (int i = 7; i >= 0; i--)
         if (m[i]) r = 3'(i);
      return r;
   endfunction
endpackage

// File: rtl/max7219_frame_driver_spi_word_tx.sv
// spi_word_tx: 16-bit MSB-first SPI word shifter, CLK_DIV clk cycles per SCK half-period.
module spi_word_tx #(
   parameter int CLK_DIV = 2
) (
   input  logic        clk,
   input  logic        res,
   input  logic        start,
   input  logic [15:0] word,
   output logic        cs,
   output logic        sck,
   output logic        mosi,
   output logic        done
);
   localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
   logic [15:0]   sr;
   logic [3:0]    bits;
   logic [DW-1:0] dcnt;
   logic          tick;
   assign tick = dcnt == DW'(CLK_DIV - 1);
   assign done = !cs && sck && tick && bits == 4'd0;
   // zeros shift in behind the word, so mosi returns low after bit 0
   assign mosi = sr[15];
   always_ff @(posedge clk or posedge res)
      if (res) begin
         cs   <= 1'b1;
         sck  <= 1'b0;
         sr   <= '0;
         bits <= '0;
         dcnt <= '0;
      end else if (cs) begin
         if (start) begin
            cs   <= 1'b0;
            sr   <= word;
            bits <= 4'd15;
            dcnt <= '0;
         end
      end else begin
         dcnt <= tick ? '0 : dcnt + 1'b1;
         if (tick) begin
            sck <= !sck;
            if (sck) begin
               sr   <= sr << 1;
               bits <= bits - 1'b1;
               cs   <= bits == 4'd0;
            end
         end
      end
endmodule

// File: rtl/max7219_frame_driver.sv
// max7219_frame_driver: MAX7219 init sequence, intensity tracking and frame-to-SPI sequencing.
// Define MAX7219_DIFF_UPDATE_EN to send only digit positions that changed since last sent.
module max7219_frame_driver
   import max7219_pkg::*;
#(
   parameter int NUM_DIGITS = 6,
   parameter int CLK_DIV    = 2,
   parameter int CS_GAP     = 4
) (
   input  logic                    clk,
   input  logic                    res,
   input  logic                    frame_valid,
   output logic                    frame_ready,
   input  logic [4*NUM_DIGITS-1:0] digits,
   input  logic [NUM_DIGITS-1:0]   dp,
   input  logic [3:0]              intensity,
   output logic                    init_done,
   output logic                    busy,
   output logic                    cs,
   output logic                    sck,
   output logic                    mosi
);
   localparam int GW = CS_GAP > 1 ? $clog2(CS_GAP) : 1;
   state_t        state, nxt;
   logic [2:0]    idx;
   logic [7:0]    mask, rem, new_mask, dp_f;
   logic [31:0]   dig_f;
   logic [3:0]    int_reg;
   logic [GW-1:0] gcnt;
   logic [15:0]   word, int_word, init_word;
   logic          int_mode, int_pend, int_sel, hs, start, done, gap_end, last;
   assign int_pend = intensity != int_reg;
   assign hs       = state == S_IDLE && !int_pend && frame_valid;
   assign gap_end  = gcnt == GW'(CS_GAP - 1);
   assign rem      = mask & ~(8'd1 << idx);
   assign last     = !init_done ? idx == 3'd4 : int_mode || rem == 8'd0;
   assign int_sel  = int_mode || (!init_done && idx == 3'd4);
   assign int_word = build_word(REG_INTENSITY, {4'h0, intensity});
   assign init_word = idx == 3'd0 ? build_word(REG_SHUTDOWN, 8'h01) :
                      idx == 3'd1 ? build_word(REG_TEST, 8'h00) :
                      idx == 3'd2 ? build_word(REG_DECODE, 8'hFF) :
                      idx == 3'd3 ? build_word(REG_SCAN_LIMIT, 8'(NUM_DIGITS - 1)) : int_word;
   assign word = int_mode ? int_word : !init_done ? init_word :
                 build_word(REG_DIGIT0 + {1'b0, idx}, {dp_f[idx], 3'b000, dig_f[{idx, 2'b00} +: 4]});
`ifdef MAX7219_DIFF_UPDATE_EN
   logic [39:0] shadow;
   logic [7:0]  sh_valid;
   always_comb begin
      new_mask = 8'h00;
      for (int i = 0; i < NUM_DIGITS; i++)
         new_mask[i] = !sh_valid[i] || shadow[5*i +: 5] != {dp[i], digits[4*i +: 4]};
   end
   always_ff @(posedge clk or posedge res)
      if (res) begin
         shadow   <= '0;
         sh_valid <= '0;
      end else if (state == S_LOAD && init_done && !int_mode) begin
         shadow[5*idx +: 5] <= {dp_f[idx], dig_f[{idx, 2'b00} +: 4]};
         sh_valid[idx]      <= 1'b1;
      end
`else
   localparam logic [7:0] ALL = 8'((1 << NUM_DIGITS) - 1);
   assign new_mask = ALL;
`endif
   always_ff @(posedge clk or posedge res)
      if (res) state <= S_INIT;
      else state <= nxt;
   always_comb begin
      nxt         = state;
      frame_ready = 1'b0;
      start       = state == S_LOAD;
      busy        = !res && !(state == S_IDLE && !int_pend);
      case (state)
         S_INIT:  nxt = S_LOAD;
         S_IDLE: begin
            frame_ready = !int_pend;
            nxt = int_pend || (frame_valid && |new_mask) ? S_LOAD : S_IDLE;
         end
         S_LOAD:  nxt = S_SHIFT;
         S_SHIFT: nxt = done ? S_GAP : S_SHIFT;
         S_GAP:   nxt = !gap_end ? S_GAP : last ? S_IDLE : S_LOAD;
         default: nxt = S_INIT;
      endcase
   end
   always_ff @(posedge clk or posedge res)
      if (res) begin
         idx       <= '0;
         mask      <= '0;
         dig_f     <= '0;
         dp_f      <= '0;
         int_reg   <= '0;
         int_mode  <= 1'b0;
         init_done <= 1'b0;
         gcnt      <= '0;
      end else begin
         gcnt <= state == S_GAP ? gcnt + 1'b1 : '0;
         if (state == S_IDLE && int_pend) int_mode <= 1'b1;
         if (hs) begin
            dig_f <= 32'(digits);
            dp_f  <= 8'(dp);
            mask  <= new_mask;
            idx   <= first_set(new_mask);
         end
         if (state == S_LOAD && int_sel) int_reg <= intensity;
         if (state == S_GAP && gap_end) begin
            if (!init_done) begin
               init_done <= last;
               idx       <= last ? 3'd0 : idx + 1'b1;
            end else if (int_mode) int_mode <= 1'b0;
            else begin
               mask <= rem;
               idx  <= first_set(rem);
            end
         end
      end
   spi_word_tx #(.CLK_DIV(CLK_DIV)) u_tx (
      .clk(clk),
      .res(res),
      .start(start),
      .word(word),
      .cs(cs),
      .sck(sck),
      .mosi(mosi),
      .done(done)
   );
endmodule

// File: tb/tb_max7219_frame_driver.sv
// tb_max7219_frame_driver: frame table plus scoreboarded SPI word monitor for max7219_frame_driver.
module tb_max7219_frame_driver;
   localparam int N = 6, CLK_DIV = 2, CS_GAP = 4;
   localparam int PERIOD = 32*CLK_DIV + CS_GAP + 1;
   logic clk = 0, res = 1, frame_valid = 0;
   logic frame_ready, init_done, busy, cs, sck, mosi;
   logic [23:0] digits = '0;
   logic [5:0]  dp = '0;
   logic [3:0]  intensity = 4'd5;
   int checks = 0, failures = 0, cyc = 0, hs_cyc = 0;
   logic [15:0] exp_q[$];
   int falls[$];
   logic in_word = 0, pcs = 1, psck = 0, pmosi = 0, bad = 0;
   int run = 0, nb = 0;
   logic [15:0] sh = '0;

   typedef struct packed {
      logic [23:0]       d;
      logic [5:0]        p;
      logic [5:0][15:0]  w;
   } vec_t;
   vec_t tbl[3];

   max7219_frame_driver #(.NUM_DIGITS(N), .CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)) dut (
      .clk(clk), .res(res), .frame_valid(frame_valid), .frame_ready(frame_ready),
      .digits(digits), .dp(dp), .intensity(intensity), .init_done(init_done),
      .busy(busy), .cs(cs), .sck(sck), .mosi(mosi)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         failures++;
         $display("FAIL %s: got %0h want %0h", name, act, want);
      end
   endtask

   // SPI monitor: decodes each cs-low window and compares against the scoreboard
   always @(negedge clk) begin
      if (res) in_word = 0;
      else if (!cs && pcs) begin
         in_word = 1; nb = 0; run = 1; sh = '0; bad = sck;
         falls.push_back(cyc);
      end else if (in_word && !cs) begin
         if (sck != psck) begin
            if (run != CLK_DIV) bad = 1;
            run = 1;
            if (sck) begin
               sh = {sh[14:0], mosi};
               nb++;
               if (mosi != pmosi) bad = 1;
            end
         end else begin
            run++;
            if (mosi != pmosi) bad = 1;
         end
      end else if (in_word && cs) begin
         in_word = 0;
         if (run != CLK_DIV || sck) bad = 1;
         if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL word: got %h want none", sh);
         end else check("word", sh, exp_q.pop_front());
         check("bits", nb, 16);
         check("sck_timing", bad, 0);
      end
      pcs = cs; psck = sck; pmosi = mosi;
   end

   function automatic vec_t mk(input logic [23:0] d, input logic [5:0] p,
                               input logic [15:0] a, b, c, e, f, g);
      vec_t r;
      r.d = d; r.p = p; r.w = {g, f, e, c, b, a};
      return r;
   endfunction

   task automatic send_frame(input logic [23:0] d, input logic [5:0] p);
      int n = 0;
      digits = d; dp = p; frame_valid = 1;
      #1;
      while (!frame_ready && n < 3000) begin
         @(negedge clk); #1; n++;
      end
      check("handshake_timeout", n < 3000, 1);
      hs_cyc = cyc;
      @(posedge clk); #1;
      frame_valid = 0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      do begin
         @(negedge clk); #1; n++;
      end while ((busy || in_word || exp_q.size() != 0) && n < 5000);
      check({name, "_idle_timeout"}, n < 5000, 1);
   endtask

   task automatic check_periods(input string name, input int from);
      for (int i = from; i < falls.size(); i++)
         check({name, "_period"}, falls[i] - falls[i-1], PERIOD);
   endtask

   task automatic do_frame(input string name, input vec_t v, input int nw);
      for (int i = 0; i < nw; i++) exp_q.push_back(v.w[i]);
      falls.delete();
      send_frame(v.d, v.p);
      wait_idle(name);
      check({name, "_nwords"}, falls.size(), nw);
      if (falls.size() > 0) check({name, "_latency"}, falls[0] - hs_cyc, 2);
      check_periods(name, 1);
   endtask

   task automatic push_init(input logic [3:0] inten);
      exp_q.push_back(16'h0C01);
      exp_q.push_back(16'h0F00);
      exp_q.push_back(16'h09FF);
      exp_q.push_back(16'h0B05);
      exp_q.push_back({12'h0A0, inten});
   endtask

   initial begin
      tbl[0] = mk(24'h054321, 6'b000100, 16'h0101, 16'h0202, 16'h0383, 16'h0404, 16'h0505, 16'h0600);
      tbl[1] = mk(24'h476789, 6'b100001, 16'h0189, 16'h0208, 16'h0307, 16'h0406, 16'h0507, 16'h0684);
      tbl[2] = mk(24'hFEDCBA, 6'b000000, 16'h010A, 16'h020B, 16'h030C, 16'h040D, 16'h050E, 16'h060F);

      @(negedge clk); #1;
      check("rst_cs", cs, 1);
      check("rst_sck", sck, 0);
      check("rst_mosi", mosi, 0);
      check("rst_ready", frame_ready, 0);
      check("rst_init_done", init_done, 0);
      check("rst_busy", busy, 0);

      push_init(4'd5);
      falls.delete();
      res = 0;
      wait_idle("init");
      check("init_nwords", falls.size(), 5);
      check_periods("init", 1);
      check("init_done", init_done, 1);
      check("init_ready", frame_ready, 1);
      check("init_busy", busy, 0);

      for (int t = 0; t < 3; t++) do_frame($sformatf("frame%0d", t), tbl[t], N);

      // intensity change wins over a frame already on offer
      exp_q.push_back(16'h0A0C);
      for (int i = 0; i < N; i++) exp_q.push_back(tbl[0].w[i]);
      falls.delete();
      intensity = 4'd12;
      digits = tbl[0].d; dp = tbl[0].p; frame_valid = 1;
      #1;
      check("int_ready_low", frame_ready, 0);
      check("int_busy", busy, 1);
      send_frame(tbl[0].d, tbl[0].p);
      wait_idle("intensity");
      check("int_nwords", falls.size(), N + 1);
      if (falls.size() > 1) begin
         check("int_hs_after_word", hs_cyc > falls[0] + 32*CLK_DIV, 1);
         check("int_latency", falls[1] - hs_cyc, 2);
      end
      check_periods("int", 2);

`ifdef MAX7219_DIFF_UPDATE_EN
      do_frame("diff_one", mk(24'h054329, 6'b000100, 16'h0109, 0, 0, 0, 0, 0), 1);
      do_frame("diff_same", mk(24'h054329, 6'b000100, 0, 0, 0, 0, 0, 0), 0);
      repeat (20) @(negedge clk);
      check("diff_same_nocs", falls.size(), 0);
      check("diff_same_ready", frame_ready, 1);
`else
      do_frame("repeat_d0", mk(24'h054329, 6'b000100, 16'h0109, 16'h0202, 16'h0383, 16'h0404, 16'h0505, 16'h0600), N);
      do_frame("repeat_same", mk(24'h054329, 6'b000100, 16'h0109, 16'h0202, 16'h0383, 16'h0404, 16'h0505, 16'h0600), N);
`endif

      // reset while bit 7 of the third digit word is on the wire
      for (int i = 0; i < N; i++) exp_q.push_back(tbl[1].w[i]);
      falls.delete();
      send_frame(tbl[1].d, tbl[1].p);
      begin
         int n = 0;
         while (!(falls.size() == 3 && nb == 8 && !sck && in_word) && n < 2000) begin
            @(negedge clk); #1; n++;
         end
         check("midreset_reach", n < 2000, 1);
      end
      #1 res = 1;
      #1;
      check("midreset_cs", cs, 1);
      check("midreset_sck", sck, 0);
      check("midreset_mosi", mosi, 0);
      check("midreset_busy", busy, 0);
      check("midreset_init_done", init_done, 0);
      exp_q.delete();
      repeat (3) @(negedge clk);
      #1;
      push_init(4'd12);
      falls.delete();
      res = 0;
      wait_idle("reinit");
      check("reinit_nwords", falls.size(), 5);
      check_periods("reinit", 1);
      check("reinit_done", init_done, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
